// File: rtl/player_executor.sv
// Player-instruction consumer: decodes the 16-bit bus from the game state machine and
// owns the soul position inside the dodge box, the player HP and the death state.
module player_executor #(
    parameter logic [9:0]  BOX_X_MIN = 10'd220,
    parameter logic [9:0]  BOX_X_MAX = 10'd420,
    parameter logic [9:0]  BOX_Y_MIN = 10'd240,
    parameter logic [9:0]  BOX_Y_MAX = 10'd400,
    parameter logic [3:0]  STEP      = 4'd2,
    parameter logic [19:0] MOVE_DIV  = 20'd100000,
    parameter logic [7:0]  HP_MAX    = 8'd100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] playerInstruction,
    output logic [9:0]  playerX,
    output logic [9:0]  playerY,
    output logic [7:0]  playerHP,
    output logic        isMove,
    output logic        isDeath,
    output logic [1:0]  execState
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACTIVE = 2'b01,
        S_DEAD   = 2'b10
    } state_t;

    localparam logic [3:0] OP_HPY = 4'd1;
    localparam logic [3:0] OP_DPY = 4'd2;
    localparam logic [3:0] OP_IDG = 4'd3;
    localparam logic [3:0] OP_SDG = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_SHP = 4'd6;

    localparam logic [10:0] X_SUM   = {1'b0, BOX_X_MIN} + {1'b0, BOX_X_MAX};
    localparam logic [10:0] Y_SUM   = {1'b0, BOX_Y_MIN} + {1'b0, BOX_Y_MAX};
    localparam logic [9:0]  X_CTR   = X_SUM[10:1];
    localparam logic [9:0]  Y_CTR   = Y_SUM[10:1];
    localparam logic [9:0]  STEP10  = {6'd0, STEP};
    localparam logic [10:0] STEP11  = {7'd0, STEP};

    state_t      state_q, state_d;
    logic [15:0] prev_instr_q, prev_instr_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [7:0]  hp_q, hp_d;
    logic [19:0] cnt_q, cnt_d;
    logic        is_move_q, is_move_d;

    logic [3:0]  opcode, dir;
    logic [7:0]  operand;
    logic        is_new;
    logic [9:0]  x_step, y_step;
    logic [7:0]  hp_dmg, hp_set;

    assign opcode  = playerInstruction[15:12];
    assign dir     = playerInstruction[11:8];
    assign operand = playerInstruction[7:0];
    assign is_new  = (playerInstruction != prev_instr_q);
    assign hp_dmg  = (hp_q > operand) ? (hp_q - operand) : 8'd0;
    assign hp_set  = (operand > HP_MAX) ? HP_MAX : operand;

    // Wall comparisons are 11-bit so a decrement near zero clamps instead of wrapping.
    always_comb begin
        x_step = x_q;
        y_step = y_q;
        case (dir)
            4'd0: y_step = ({1'b0, y_q} < ({1'b0, BOX_Y_MIN} + STEP11)) ? BOX_Y_MIN : (y_q - STEP10);
            4'd1: x_step = (({1'b0, x_q} + STEP11) > {1'b0, BOX_X_MAX}) ? BOX_X_MAX : (x_q + STEP10);
            4'd2: y_step = (({1'b0, y_q} + STEP11) > {1'b0, BOX_Y_MAX}) ? BOX_Y_MAX : (y_q + STEP10);
            4'd3: x_step = ({1'b0, x_q} < ({1'b0, BOX_X_MIN} + STEP11)) ? BOX_X_MIN : (x_q - STEP10);
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        prev_instr_d = playerInstruction;
        x_d          = x_q;
        y_d          = y_q;
        hp_d         = hp_q;
        cnt_d        = 20'd0;
        is_move_d    = 1'b0;

        if (state_q == S_DEAD) begin
            if (is_new && opcode == OP_HPY && operand != 8'd0) begin
                hp_d    = hp_set;
                state_d = S_IDLE;
            end
        end else begin
            if (is_new) begin
                case (opcode)
                    OP_HPY: begin
                        hp_d = hp_set;
                        if (operand == 8'd0) state_d = S_DEAD;
                    end
                    OP_DPY: begin
                        hp_d = hp_dmg;
                        if (hp_dmg == 8'd0) state_d = S_DEAD;
                    end
                    OP_IDG: begin
                        x_d     = X_CTR;
                        y_d     = Y_CTR;
                        state_d = S_IDLE;
                    end
                    OP_SDG: state_d = S_ACTIVE;
                    OP_SHP: hp_d = HP_MAX;
                    default: ;
                endcase
            end
            // MOV is level-sensitive; the counter survives direction changes while held.
            if (state_q == S_ACTIVE && opcode == OP_MOV) begin
                if (cnt_q == MOVE_DIV - 20'd1) begin
                    x_d       = x_step;
                    y_d       = y_step;
                    is_move_d = (x_step != x_q) || (y_step != y_q);
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            prev_instr_q <= 16'h0000;
            x_q          <= X_CTR;
            y_q          <= Y_CTR;
            hp_q         <= HP_MAX;
            cnt_q        <= 20'd0;
            is_move_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_instr_q <= prev_instr_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hp_q         <= hp_d;
            cnt_q        <= cnt_d;
            is_move_q    <= is_move_d;
        end
    end

    assign playerX   = x_q;
    assign playerY   = y_q;
    assign playerHP  = hp_q;
    assign isMove    = is_move_q;
    assign isDeath   = (state_q == S_DEAD);
    assign execState = state_q;

endmodule

// File: tb/tb_player_executor.sv
// Directed bench for player_executor with a 4-clock move tick; expected values are
// hand-computed from the box geometry (centre 320/320, step 2, walls 220..420 / 240..400).
module tb_player_executor;

    logic        clk;
    logic        reset;
    logic [15:0] playerInstruction;
    logic [9:0]  playerX;
    logic [9:0]  playerY;
    logic [7:0]  playerHP;
    logic        isMove;
    logic        isDeath;
    logic [1:0]  execState;

    int nChecks = 0;
    int nFails  = 0;
    int moves;
    int ticks;

    player_executor #(.MOVE_DIV(20'd4)) dut (
        .clk               (clk),
        .reset             (reset),
        .playerInstruction (playerInstruction),
        .playerX           (playerX),
        .playerY           (playerY),
        .playerHP          (playerHP),
        .isMove            (isMove),
        .isDeath           (isDeath),
        .execState         (execState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [3:0] dir, input logic [7:0] arg);
        playerInstruction = {op, dir, arg};
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        playerInstruction = 16'h0000;
        tick();
        tick();

        checkOutput("reset_x", {6'd0, playerX}, 16'd320);
        checkOutput("reset_y", {6'd0, playerY}, 16'd320);
        checkOutput("reset_hp", {8'd0, playerHP}, 16'd100);
        checkOutput("reset_move", {15'd0, isMove}, 16'd0);
        checkOutput("reset_death", {15'd0, isDeath}, 16'd0);
        checkOutput("reset_state", {14'd0, execState}, 16'd0);
        reset = 1'b0;
        tick();

        // SDG then MOV right for 12 clocks: steps at clocks 4, 8, 12
        applyStimulus(4'd4, 4'd0, 8'd0);
        tick();
        checkOutput("sdg_state", {14'd0, execState}, 16'd1);
        applyStimulus(4'd5, 4'd1, 8'd0);
        moves = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (isMove) moves++;
            if (i % 4 == 0) checkOutput("right_x", {6'd0, playerX}, 16'(320 + 2 * (i / 4)));
        end
        checkOutput("right_pulses", 16'(moves), 16'd3);
        checkOutput("right_y", {6'd0, playerY}, 16'd320);

        // IDG recentres and returns to IDLE
        applyStimulus(4'd3, 4'd0, 8'd0);
        tick();
        checkOutput("idg_x", {6'd0, playerX}, 16'd320);
        checkOutput("idg_state", {14'd0, execState}, 16'd0);

        // MOV in IDLE is ignored
        applyStimulus(4'd5, 4'd0, 8'd0);
        moves = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (isMove) moves++;
        end
        checkOutput("idle_pulses", 16'(moves), 16'd0);
        checkOutput("idle_y", {6'd0, playerY}, 16'd320);

        applyStimulus(4'd4, 4'd0, 8'd0);
        tick();
        applyStimulus(4'd5, 4'd0, 8'd0);
        repeat (4) tick();
        checkOutput("up_y1", {6'd0, playerY}, 16'd318);
        repeat (4) tick();
        checkOutput("up_y2", {6'd0, playerY}, 16'd316);

        // MOV left until the wall: 50 steps of 4 clocks, then hold at 220
        applyStimulus(4'd5, 4'd3, 8'd0);
        ticks = 0;
        for (int i = 0; i < 300 && playerX != 10'd220; i++) begin
            tick();
            ticks++;
        end
        checkOutput("left_reach_x", {6'd0, playerX}, 16'd220);
        checkOutput("left_ticks", 16'(ticks), 16'd200);
        moves = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (isMove) moves++;
        end
        checkOutput("wall_pulses", 16'(moves), 16'd0);
        checkOutput("wall_x", {6'd0, playerX}, 16'd220);

        // Direction change mid-count keeps the counter
        applyStimulus(4'd3, 4'd0, 8'd0);
        tick();
        applyStimulus(4'd4, 4'd0, 8'd0);
        tick();
        applyStimulus(4'd5, 4'd1, 8'd0);
        tick();
        tick();
        applyStimulus(4'd5, 4'd2, 8'd0);
        tick();
        checkOutput("dirchg_y_early", {6'd0, playerY}, 16'd320);
        tick();
        checkOutput("dirchg_y", {6'd0, playerY}, 16'd322);
        checkOutput("dirchg_x", {6'd0, playerX}, 16'd320);
        checkOutput("dirchg_move", {15'd0, isMove}, 16'd1);

        // DPY held executes once
        applyStimulus(4'd2, 4'd0, 8'd30);
        tick();
        checkOutput("dpy_hp1", {8'd0, playerHP}, 16'd70);
        repeat (9) tick();
        checkOutput("dpy_hp_held", {8'd0, playerHP}, 16'd70);

        applyStimulus(4'd2, 4'd0, 8'd200);
        tick();
        checkOutput("kill_hp", {8'd0, playerHP}, 16'd0);
        checkOutput("kill_death", {15'd0, isDeath}, 16'd1);
        checkOutput("kill_state", {14'd0, execState}, 16'd2);

        // DEAD ignores SDG, MOV, SHP
        applyStimulus(4'd4, 4'd0, 8'd0);
        tick();
        applyStimulus(4'd5, 4'd1, 8'd0);
        moves = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (isMove) moves++;
        end
        applyStimulus(4'd6, 4'd0, 8'd0);
        tick();
        checkOutput("dead_pulses", 16'(moves), 16'd0);
        checkOutput("dead_x", {6'd0, playerX}, 16'd320);
        checkOutput("dead_hp", {8'd0, playerHP}, 16'd0);
        checkOutput("dead_state", {14'd0, execState}, 16'd2);

        applyStimulus(4'd1, 4'd0, 8'd50);
        tick();
        checkOutput("revive_hp", {8'd0, playerHP}, 16'd50);
        checkOutput("revive_state", {14'd0, execState}, 16'd0);
        checkOutput("revive_death", {15'd0, isDeath}, 16'd0);

        // HPY clamps to HP_MAX, DPY then SHP heals fully
        applyStimulus(4'd1, 4'd0, 8'd200);
        tick();
        checkOutput("hpy_clamp", {8'd0, playerHP}, 16'd100);
        applyStimulus(4'd2, 4'd0, 8'd10);
        tick();
        checkOutput("dpy10_hp", {8'd0, playerHP}, 16'd90);
        applyStimulus(4'd6, 4'd0, 8'd0);
        tick();
        checkOutput("shp_hp", {8'd0, playerHP}, 16'd100);

        // HPY 0 outside DEAD kills
        applyStimulus(4'd1, 4'd0, 8'd0);
        tick();
        checkOutput("hpy0_hp", {8'd0, playerHP}, 16'd0);
        checkOutput("hpy0_state", {14'd0, execState}, 16'd2);
        applyStimulus(4'd1, 4'd0, 8'd40);
        tick();
        checkOutput("hpy40_hp", {8'd0, playerHP}, 16'd40);

        // Asynchronous reset mid-move
        applyStimulus(4'd4, 4'd0, 8'd0);
        tick();
        applyStimulus(4'd5, 4'd1, 8'd0);
        repeat (6) tick();
        checkOutput("premove_x", {6'd0, playerX}, 16'd322);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_x", {6'd0, playerX}, 16'd320);
        checkOutput("async_y", {6'd0, playerY}, 16'd320);
        checkOutput("async_hp", {8'd0, playerHP}, 16'd100);
        checkOutput("async_state", {14'd0, execState}, 16'd0);
        applyStimulus(4'd0, 4'd0, 8'd0);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("post_reset_hp", {8'd0, playerHP}, 16'd100);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
